mux2_bus_arbiter: RTL and testbench
===================================

MUX2_BUS_ARBITER -- requirements
Module: mux2_bus_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the data width of each source and of the output.
REQ-002 The block SHALL have parameter MAX_BURST, default 4, giving the maximum consecutive grants to one owner while the other requests; legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports req0/req1, input, 1 bit each: source 0/1 has a word to transfer.
REQ-006 The block SHALL have ports d0/d1, input, DATA_W each: source 0/1 data, held stable while req is high.
REQ-007 The block SHALL have ports gnt0/gnt1, output, 1 bit each: combinational grant; transfer occurs in any cycle where gnt is high.
REQ-008 The block SHALL have port sel, output, 1 bit: select for the shared 2:1 data mux (0 = d0, 1 = d1).
REQ-009 The block SHALL have port out_valid, output, 1 bit: the output register holds a word.
REQ-010 The block SHALL have port out_data, output, DATA_W: the registered output word.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the word when out_valid and out_ready are both high.
REQ-012 The block SHALL have port busy, output, 1 bit: high when state != IDLE or out_valid = 1.

Function
REQ-013 The block SHALL define slot_free = !out_valid || out_ready; it SHALL issue no grant in a cycle where slot_free = 0, and state, cnt and sel SHALL then hold.
REQ-014 The block SHALL keep FSM states IDLE, OWN0 and OWN1, a counter cnt (4 bits, saturating at MAX_BURST), and a flag last (index of the most recent grant).
REQ-015 In IDLE with slot_free, the block SHALL grant the single requester; if req0 and req1 are both high, it SHALL grant index !last. It SHALL then go to OWNx with cnt = 1; with no request it SHALL stay in IDLE.
REQ-016 In OWNx with slot_free, when reqx = 1 and (cnt < MAX_BURST or req of the other source = 0), the block SHALL grant x and set cnt = min(cnt+1, MAX_BURST).
REQ-017 Otherwise in OWNx with slot_free, when the other source requests, the block SHALL grant the other source, go to OWN(other) and set cnt = 1.
REQ-018 In OWNx with slot_free and no request, the block SHALL go to IDLE with cnt = 0 and issue no grant.
REQ-019 At most one of gnt0/gnt1 SHALL be high in any cycle, and a grant SHALL never be issued to a source whose req is low.
REQ-020 sel SHALL equal the granted index in a grant cycle and SHALL hold its previous registered value otherwise.
REQ-021 On a grant in cycle N, out_data SHALL be loaded with the selected d and out_valid SHALL be 1 from cycle N+1, giving a latency of 1 cycle.
REQ-022 When out_valid and out_ready are high and there is no grant in the same cycle, out_valid SHALL clear next cycle and out_data SHALL hold.
REQ-023 A drain and a grant in the same cycle SHALL give back-to-back transfers with out_valid staying 1, sustaining 1 word per cycle.
REQ-024 last SHALL update to the granted index on every grant.
REQ-025 A source dropping req without a grant SHALL be legal and SHALL cause no transfer.

Reset
REQ-026 While rst_n = 0 (asynchronous assertion), the block SHALL force state = IDLE, cnt = 0, last = 1, sel = 0, out_valid = 0, out_data = 0 and busy = 0, and gnt0/gnt1 SHALL be 0.
REQ-027 Reset asserted mid-burst SHALL discard any held word with no partial transfer, and the first grant after release SHALL follow IDLE rules.

Verification
REQ-028 Scenario: reset, then req0 = req1 = 1 with out_ready = 1 -> first grant gnt0, out_data = d0 next cycle, then gnt0 for 4 consecutive cycles, then gnt1 for 4 cycles, alternating.
REQ-029 Scenario: req0 = 1 only, d0 = 0xA5A5A5A5, out_ready = 1 for 10 cycles -> gnt0 every cycle, no forced switch, out_data = 0xA5A5A5A5 with out_valid continuously 1.
REQ-030 Scenario: one word transferred then out_ready = 0 for 3 cycles with req1 = 1 -> gnt1 stays 0 and out_data stays stable; gnt1 is asserted in the cycle out_ready returns to 1.
REQ-031 Scenario: requests stop in OWN1 -> state IDLE next cycle; busy drops after the last word drains.
REQ-032 Scenario: rst_n pulsed low mid-burst with out_valid = 1 -> out_valid = 0 and out_data = 0 immediately, with no clock edge needed.
REQ-033 Scenario: random req and out_ready for 10k cycles -> never both grants high, no grant to an idle source, every granted word appears once in order, and no requester waits more than MAX_BURST grants of the other.

Source files
------------

// File: rtl/mux2_bus_arbiter.sv
// Two-source bus arbiter with burst-limited fairness, feeding a shared 2:1 mux
// and a single registered output slot that can accept a new word every cycle.
module mux2_bus_arbiter #(
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic [DATA_W-1:0] d0,
   input  logic [DATA_W-1:0] d1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              sel,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic              r_last;
   logic              r_sel;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;

   logic w_slot_free;
   logic w_gnt0;
   logic w_gnt1;
   logic w_gnt;
   logic w_gidx;
   logic w_same_owner;

   assign w_slot_free = !r_out_valid || out_ready;

   // Grants are held off while reset is asserted so no word leaks out of a reset pulse.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (w_slot_free && rst_n) begin
         case (r_state)
            IDLE: begin
               if (req0 && req1) begin
                  w_gnt0 = r_last;
                  w_gnt1 = !r_last;
               end else begin
                  w_gnt0 = req0;
                  w_gnt1 = req1;
               end
            end
            OWN0: begin
               if (req0 && ((r_cnt < MAX_CNT) || !req1)) w_gnt0 = 1'b1;
               else                                      w_gnt1 = req1;
            end
            OWN1: begin
               if (req1 && ((r_cnt < MAX_CNT) || !req0)) w_gnt1 = 1'b1;
               else                                      w_gnt0 = req0;
            end
            default: ;
         endcase
      end
   end

   assign w_gnt        = w_gnt0 || w_gnt1;
   assign w_gidx       = w_gnt1;
   assign w_same_owner = (w_gidx && (r_state == OWN1)) || (!w_gidx && (r_state == OWN0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_last      <= 1'b1;
         r_sel       <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_gnt) begin
         r_state     <= w_gidx ? OWN1 : OWN0;
         r_last      <= w_gidx;
         r_sel       <= w_gidx;
         r_out_valid <= 1'b1;
         r_out_data  <= w_gidx ? d1 : d0;
         if (w_same_owner) r_cnt <= (r_cnt < MAX_CNT) ? r_cnt + 4'd1 : MAX_CNT;
         else              r_cnt <= 4'd1;
      end else begin
         if (out_ready) r_out_valid <= 1'b0;
         // A free slot with no grant can only mean nobody is requesting.
         if (w_slot_free) begin
            r_state <= IDLE;
            r_cnt   <= '0;
         end
      end
   end

   assign gnt0      = w_gnt0;
   assign gnt1      = w_gnt1;
   assign sel       = w_gnt ? w_gidx : r_sel;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign busy      = (r_state != IDLE) || r_out_valid;

endmodule

// File: tb/tb_mux2_bus_arbiter.sv
// Bench for mux2_bus_arbiter: directed table, hand-written corner sequences and
// a long random run against a behavioural model plus an in-order scoreboard.
module tb_mux2_bus_arbiter;

   localparam int W    = 32;
   localparam int MAXB = 4;
   localparam logic [W-1:0] D0 = 32'h0000_D0D0;
   localparam logic [W-1:0] D1 = 32'h0000_D1D1;

   logic         clk;
   logic         rst_n;
   logic         req0, req1, out_ready;
   logic [W-1:0] d0, d1;
   logic         gnt0, gnt1, sel, out_valid, busy;
   logic [W-1:0] out_data;

   mux2_bus_arbiter #(.DATA_W(W), .MAX_BURST(MAXB)) dut (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
      .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .out_valid(out_valid),
      .out_data(out_data), .out_ready(out_ready), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model: who currently holds the bus (-1 = nobody), how long its run is,
   // who was served last, and what the output slot holds.
   int           m_owner, m_run, m_last, m_g;
   bit           m_sel, m_valid;
   logic [W-1:0] m_data;
   logic [W-1:0] sb[$];
   int           wait0, wait1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic void model_reset();
      m_owner = -1; m_run = 0; m_last = 1; m_sel = 1'b0; m_valid = 1'b0; m_data = '0;
      sb.delete(); wait0 = 0; wait1 = 0;
   endfunction

   // Holder keeps the bus until its quota is used up while the other side waits.
   function automatic int model_grant(input bit r0, input bit r1, input bit rdy);
      bit own_r, oth_r;
      if (m_valid && !rdy) return -1;
      if (m_owner < 0) begin
         if (r0 && r1) return 1 - m_last;
         if (r0) return 0;
         if (r1) return 1;
         return -1;
      end
      own_r = (m_owner == 1) ? r1 : r0;
      oth_r = (m_owner == 1) ? r0 : r1;
      if (own_r && (m_run < MAXB || !oth_r)) return m_owner;
      if (oth_r) return 1 - m_owner;
      return -1;
   endfunction

   task automatic drive(input bit r0, input bit r1, input bit rdy,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      bit slot;
      @(negedge clk);
      req0 = r0; req1 = r1; out_ready = rdy; d0 = a; d1 = b;
      #1;
      m_g = model_grant(r0, r1, rdy);
      check("gnt0", 64'(gnt0), 64'(m_g == 0));
      check("gnt1", 64'(gnt1), 64'(m_g == 1));
      check("sel", 64'(sel), 64'((m_g >= 0) ? (m_g == 1) : m_sel));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      check("out_data", 64'(out_data), 64'(m_data));
      check("busy", 64'(busy), 64'((m_owner >= 0) || m_valid));
      check("onehot", 64'(gnt0 & gnt1), 64'(0));
      check("gnt0_noreq", 64'(gnt0 & !r0), 64'(0));
      check("gnt1_noreq", 64'(gnt1 & !r1), 64'(0));
      if (out_valid && rdy) begin
         if (sb.size() == 0) check("sb_extra", 64'(1), 64'(0));
         else                check("sb_order", 64'(out_data), 64'(sb.pop_front()));
      end
      if (gnt0) sb.push_back(a);
      else if (gnt1) sb.push_back(b);
      if (!r0 || gnt0) wait0 = 0; else if (gnt1) wait0++;
      if (!r1 || gnt1) wait1 = 0; else if (gnt0) wait1++;
      if (gnt0 || gnt1) begin
         check("fair0", 64'(wait0 > MAXB), 64'(0));
         check("fair1", 64'(wait1 > MAXB), 64'(0));
      end
      slot = !m_valid || rdy;
      if (m_g >= 0) begin
         m_run   = (m_g == m_owner) ? ((m_run < MAXB) ? m_run + 1 : MAXB) : 1;
         m_owner = m_g;
         m_last  = m_g;
         m_sel   = (m_g == 1);
         m_data  = (m_g == 1) ? b : a;
         m_valid = 1'b1;
      end else begin
         if (m_valid && rdy) m_valid = 1'b0;
         if (slot) begin m_owner = -1; m_run = 0; end
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      req0 = 0; req1 = 0; out_ready = 0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; req0 = 0; req1 = 0; out_ready = 0;
      @(negedge clk);
      check("rst_gnt", 64'({gnt1, gnt0}), 64'(0));
      check("rst_sel", 64'(sel), 64'(0));
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_data", 64'(out_data), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      release_reset();
   endtask

   typedef struct {
      bit           r0, r1, rdy;
      bit           g0, g1, v;
      logic [W-1:0] data;
   } vec_t;
   vec_t tbl[10];

   initial begin
      logic [W-1:0] da, db;
      bit           r0, r1, rdy;
      rst_n = 1'b0; req0 = 0; req1 = 0; out_ready = 0; d0 = '0; d1 = '0;
      model_reset();

      // Both requesting with a free consumer: bursts of four, alternating.
      for (int i = 0; i < 10; i++) begin
         tbl[i].r0 = 1; tbl[i].r1 = 1; tbl[i].rdy = 1; tbl[i].v = (i > 0);
         tbl[i].g0 = (i < 4) || (i >= 8);
         tbl[i].g1 = !tbl[i].g0;
      end
      tbl[0].data = '0;
      for (int i = 1; i < 10; i++) tbl[i].data = (tbl[i-1].g1) ? D1 : D0;

      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].r0, tbl[i].r1, tbl[i].rdy, D0, D1);
         check("tbl_gnt0", 64'(gnt0), 64'(tbl[i].g0));
         check("tbl_gnt1", 64'(gnt1), 64'(tbl[i].g1));
         check("tbl_valid", 64'(out_valid), 64'(tbl[i].v));
         check("tbl_data", 64'(out_data), 64'(tbl[i].data));
      end

      // Single requester streams without a forced switch.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1, 0, 1, 32'hA5A5_A5A5, D1);
         check("solo_gnt0", 64'(gnt0), 64'(1));
         if (i > 0) begin
            check("solo_valid", 64'(out_valid), 64'(1));
            check("solo_data", 64'(out_data), 64'(32'hA5A5_A5A5));
         end
      end

      // Back-pressure blocks the other source until the consumer is ready again.
      do_reset();
      drive(1, 0, 1, D0, D1);
      check("bp_first", 64'(gnt0), 64'(1));
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, D0, D1);
         check("bp_gnt1", 64'(gnt1), 64'(0));
         check("bp_data", 64'(out_data), 64'(D0));
         check("bp_valid", 64'(out_valid), 64'(1));
      end
      drive(0, 1, 1, D0, D1);
      check("bp_release", 64'(gnt1), 64'(1));

      // Requests stop while source 1 owns the bus; busy falls once the word drains.
      drive(0, 1, 1, D0, D1);
      check("stop_gnt1", 64'(gnt1), 64'(1));
      drive(0, 0, 0, D0, D1);
      check("stop_busy_hold", 64'(busy), 64'(1));
      drive(0, 0, 1, D0, D1);
      check("stop_busy_drain", 64'(busy), 64'(1));
      drive(0, 0, 0, D0, D1);
      check("stop_busy_idle", 64'(busy), 64'(0));
      check("stop_valid", 64'(out_valid), 64'(0));
      check("stop_data_hold", 64'(out_data), 64'(D1));

      // Asynchronous reset mid-burst clears the slot without a clock edge.
      do_reset();
      for (int i = 0; i < 3; i++) drive(1, 1, 1, D0, D1);
      check("pre_rst_valid", 64'(out_valid), 64'(1));
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(out_valid), 64'(0));
      check("arst_data", 64'(out_data), 64'(0));
      check("arst_gnt", 64'({gnt1, gnt0}), 64'(0));
      check("arst_busy", 64'(busy), 64'(0));
      check("arst_sel", 64'(sel), 64'(0));
      release_reset();
      drive(1, 1, 1, D0, D1);
      check("post_rst_gnt0", 64'(gnt0), 64'(1));

      // Random traffic against the model.
      do_reset();
      da = $urandom; db = $urandom;
      for (int i = 0; i < 10000; i++) begin
         r0  = ($urandom_range(0, 3) != 0);
         r1  = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         if (!req0) da = $urandom;
         if (!req1) db = $urandom;
         drive(r0, r1, rdy, da, db);
         if (gnt0) da = $urandom;
         if (gnt1) db = $urandom;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
